// File: rtl/bm_pkg.sv
// rtl/bm_pkg.sv - shared state type and per-step constants for bm_seq_mult8
package bm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BM_STEPS = 4;

    // Left shift applied to each step's partial product, 4 bits per step, step 0 in the LSBs.
    localparam logic [15:0] STEP_SHIFT = {4'd8, 4'd4, 4'd4, 4'd0};

    // Bit n set: step n feeds the high nibble of that operand into the array.
    localparam logic [3:0] STEP_SEL_AH = 4'b1010;
    localparam logic [3:0] STEP_SEL_BH = 4'b1100;

endpackage

// File: rtl/BM.sv
// rtl/BM.sv - 4x4 unsigned Braun array multiplier, purely combinational
module BM (
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    output logic [7:0] o_p
);

    // Each row ANDs the multiplicand with one multiplier bit and ripples into the running sum.
    always_comb begin
        o_p = 8'h00;
        for (int i = 0; i < 4; i++) begin
            o_p = o_p + ({4'h0, i_x & {4{i_y[i]}}} << i);
        end
    end

endmodule

// File: rtl/bm_seq_mult8.sv
// rtl/bm_seq_mult8.sv - sequential 8x8 unsigned multiplier sharing one 4x4 array over up to four steps
module bm_seq_mult8
    import bm_pkg::*;
#(
    parameter int EARLY_OUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);

    state_t      r_state;
    logic [1:0]  r_step;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [15:0] r_p;
    logic        r_out_valid;

    logic [3:0]  w_a_nib;
    logic [3:0]  w_b_nib;
    logic [7:0]  w_pp;
    logic [3:0]  w_shift;
    logic [15:0] w_pp_sh;
    logic [15:0] w_acc_next;
    logic        w_last;
    logic        w_accept;

    assign w_a_nib    = STEP_SEL_AH[r_step] ? r_a[7:4] : r_a[3:0];
    assign w_b_nib    = STEP_SEL_BH[r_step] ? r_b[7:4] : r_b[3:0];
    assign w_shift    = STEP_SHIFT[{r_step, 2'b00} +: 4];
    assign w_pp_sh    = {8'h00, w_pp} << w_shift;
    assign w_acc_next = r_acc + w_pp_sh;

    // With early-out, a zero high multiplier nibble makes steps 2 and 3 contribute nothing.
    assign w_last = (r_step == 2'(BM_STEPS - 1)) ||
                    ((EARLY_OUT != 0) && (r_step == 2'd1) && (r_b[7:4] == 4'h0));

    assign in_ready  = rst_n && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign p         = r_p;
    assign busy      = (r_state == MUL);

    BM u_bm (
        .i_x (w_a_nib),
        .i_y (w_b_nib),
        .o_p (w_pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_step      <= 2'd0;
            r_a         <= 8'h00;
            r_b         <= 8'h00;
            r_acc       <= 16'h0000;
            r_p         <= 16'h0000;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: ;
                MUL: begin
                    r_acc  <= w_acc_next;
                    r_step <= r_step + 2'd1;
                    if (w_last) begin
                        r_p         <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Accept only happens in IDLE or draining DONE, so it overrides the IDLE exit above.
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_acc   <= 16'h0000;
                r_step  <= 2'd0;
                r_state <= MUL;
            end
        end
    end

endmodule

// File: tb/tb_bm_seq_mult8.sv
// tb/tb_bm_seq_mult8.sv - self-checking bench for bm_seq_mult8 (normal and early-out builds)
module tb_bm_seq_mult8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] p;
    logic        in_valid_e, in_ready_e, out_valid_e, out_ready_e, busy_e;
    logic [7:0]  a_e, b_e;
    logic [15:0] p_e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bm_seq_mult8 #(.EARLY_OUT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
    );

    bm_seq_mult8 #(.EARLY_OUT(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_e), .in_ready(in_ready_e),
        .a(a_e), .b(b_e), .out_valid(out_valid_e), .out_ready(out_ready_e), .p(p_e), .busy(busy_e)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input bit early, output int cyc);
        cyc = 0;
        while (!(early ? out_valid_e : out_valid) && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] expd;
    int          cyc;
    int          sent0, got0, sent1, got1;
    logic        prev_hold0, prev_hold1;
    logic [15:0] prev_p0, prev_p1;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
        in_valid_e = 1'b0; out_ready_e = 1'b0; a_e = 8'h00; b_e = 8'h00;
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_p", p, 16'h0000);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Full-scale product with the consumer always ready.
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_in_ready_drop", in_ready, 0);
        chk("t1_busy", busy, 1);
        wait_out(1'b0, cyc);
        chk("t1_latency", cyc, 4);
        chk("t1_p", p, 16'hFE01);
        step();
        chk("t1_ov_drop", out_valid, 0);
        chk("t1_idle_ready", in_ready, 1);

        // Back-pressure holds the result stable.
        a = 8'h12; b = 8'h34; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        wait_out(1'b0, cyc);
        chk("t2_latency", cyc, 4);
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_p", p, 16'h03A8);
            chk("t2_hold_ov", out_valid, 1);
            chk("t2_hold_in_ready", in_ready, 0);
            step();
        end

        // Drain and accept on the same edge.
        out_ready = 1'b1; in_valid = 1'b1; a = 8'h0F; b = 8'hF0;
        #1;
        chk("t3_in_ready_comb", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("t3_ov_retired", out_valid, 0);
        chk("t3_busy", busy, 1);
        wait_out(1'b0, cyc);
        chk("t3_latency", cyc, 4);
        chk("t3_p", p, 16'h0E10);
        step();

        // Early-out build: zero and nonzero high multiplier nibble.
        a_e = 8'hC3; b_e = 8'h0D; in_valid_e = 1'b1; out_ready_e = 1'b1;
        step();
        in_valid_e = 1'b0;
        wait_out(1'b1, cyc);
        chk("eo_short_latency", cyc, 2);
        chk("eo_short_p", p_e, 16'h09E7);
        step();
        a_e = 8'hC3; b_e = 8'h1D; in_valid_e = 1'b1;
        step();
        in_valid_e = 1'b0;
        wait_out(1'b1, cyc);
        chk("eo_long_latency", cyc, 4);
        chk("eo_long_p", p_e, 16'h1617);
        step();

        // Reset after step 1 abandons the operation.
        a = 8'hAB; b = 8'hCD; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_p", p, 16'h0000);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mid_rst_no_ov", out_valid, 0);
        end
        rst_n = 1'b1;
        step();

        // Random pairs against a product scoreboard on both builds.
        sent0 = 0; got0 = 0; sent1 = 0; got1 = 0;
        prev_hold0 = 1'b0; prev_hold1 = 1'b0; prev_p0 = 16'h0; prev_p1 = 16'h0;
        out_ready = 1'b0; out_ready_e = 1'b0;
        for (int c = 0; c < 40000 && (got0 < 1000 || got1 < 1000); c++) begin
            @(negedge clk);
            if (prev_hold0) begin
                chk("rnd_ov_hold0", out_valid, 1);
                chk("rnd_p_hold0", p, prev_p0);
            end
            if (prev_hold1) begin
                chk("rnd_ov_hold1", out_valid_e, 1);
                chk("rnd_p_hold1", p_e, prev_p1);
            end
            prev_hold0 = out_valid && !out_ready;
            prev_hold1 = out_valid_e && !out_ready_e;
            prev_p0 = p;
            prev_p1 = p_e;
            if (out_valid && out_ready) begin
                expd = (q0.size() > 0) ? q0.pop_front() : 16'hxxxx;
                chk("rnd_p0", p, expd);
                got0++;
            end
            if (out_valid_e && out_ready_e) begin
                expd = (q1.size() > 0) ? q1.pop_front() : 16'hxxxx;
                chk("rnd_p1", p_e, expd);
                got1++;
            end
            if (in_valid && in_ready) begin
                q0.push_back(16'(a) * 16'(b));
                sent0++;
            end
            if (in_valid_e && in_ready_e) begin
                q1.push_back(16'(a_e) * 16'(b_e));
                sent1++;
            end
            step();
            in_valid    = (sent0 < 1000) && ($urandom_range(0, 1) == 1);
            a           = 8'($urandom);
            b           = 8'($urandom);
            out_ready   = ($urandom_range(0, 1) == 1);
            in_valid_e  = (sent1 < 1000) && ($urandom_range(0, 1) == 1);
            a_e         = 8'($urandom);
            b_e         = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 15));
            out_ready_e = ($urandom_range(0, 1) == 1);
        end
        chk("rnd_count0", got0, 1000);
        chk("rnd_count1", got1, 1000);
        chk("rnd_q0_empty", q0.size(), 0);
        chk("rnd_q1_empty", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bm_seq_mult8.md
# bm_seq_mult8

Sequential 8x8 unsigned multiplier that time-shares one 4x4 Braun array (`BM`) over up to four partial-product steps. It accepts operand pairs on a valid/ready handshake and accumulates the nibble products into a 16-bit result, which it presents on a second valid/ready handshake. It sits between operand producers and result consumers that need 8-bit products but cannot spend the area of a full 8x8 array.

## Interface
Parameters:
- `EARLY_OUT`, default 0: when 1, skips the two `b[7:4]` steps if `b[7:4]==0`.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: operand pair `a`/`b` is valid.
- `in_ready`, output, 1: block can accept an operand pair this cycle.
- `a`, input, 8: multiplicand, unsigned.
- `b`, input, 8: multiplier, unsigned.
- `out_valid`, output, 1: `p` holds a completed product.
- `out_ready`, input, 1: consumer accepts `p` this cycle.
- `p`, output, 16: product `a*b`.
- `busy`, output, 1: high in MUL.

## Operation
- States: IDLE, MUL, DONE.
- Accept: `in_valid && in_ready` at an edge.
  - Latches `a`/`b` into operand registers.
  - Clears the accumulator, sets the step counter to 0, and moves to MUL.
- MUL: one step per cycle. The selected nibbles drive `BM`, and the 8-bit partial product is zero-extended, shifted, and added into the 16-bit accumulator at the edge.
  - Step 0: `aL*bL`, shift 0.
  - Step 1: `aH*bL`, shift 4.
  - Step 2: `aL*bH`, shift 4.
  - Step 3: `aH*bH`, shift 8.
- Last step: after step 3, or after step 1 when `EARLY_OUT==1` and the latched `b[7:4]==0`:
  - `p` gets the final accumulator value, and the state moves to DONE.
- DONE: `out_valid=1` and `p` stays stable until `out_ready`.
  - `out_ready` without a new accept: moves to IDLE, `out_valid` drops.
- `in_ready` = `rst_n && (state==IDLE || (state==DONE && out_ready))`.
  - This gives a combinational path from `out_ready` to `in_ready`, which is intended.
- Simultaneous drain and accept in DONE (`out_ready && in_valid`): result retires and the new pair is latched in the same edge. The state goes directly to MUL.
- Arithmetic: the accumulator is 16 bits and cannot overflow (max `255*255=16'hFE01`), so no carry-out is kept.
- `p` changes only on entry to DONE; it keeps its last value in IDLE/MUL.
- `in_valid` while busy is ignored (no accept since `in_ready=0`). Operand inputs are don't-care outside accept.

## Timing
- Reset (asserted asynchronously): state IDLE, accumulator 0, `p=16'h0000`, `out_valid=0`, `busy=0`, step counter 0, operand registers 0.
  - `in_ready=0` while `rst_n` is low, 1 on the first cycle after release.
- Latency, accept edge to `out_valid` high:
  - 4 cycles normally.
  - 2 cycles with `EARLY_OUT=1` and `b[7:4]==0`.
- Throughput with `out_ready` tied high: one product per 5 cycles (3 with early-out), via DONE→MUL chaining.
- Reset mid-MUL or in DONE: operation abandoned, no `out_valid` pulse, all registers return to reset values.
- `out_valid` never deasserts without `out_ready` (except by reset).

## Structure
- Shared package `bm_pkg`:
  - state enum (IDLE/MUL/DONE).
  - `BM_STEPS=4`.
  - Per-step shift constants (0, 4, 4, 8).
  - Per-step nibble-select constants.
- Sub-module: one instance of `BM` (4x4 Braun array); all other logic is local. Logic list:
  - FSM.
  - 2-bit step counter.
  - Nibble muxes.
  - Shifter.
  - 16-bit adder/accumulator.
  - Output register.

## Test plan
- Reset release, `a=8'hFF`, `b=8'hFF`, `in_valid` one cycle, `out_ready=1`:
  - `in_ready` drops after accept.
  - `out_valid` rises 4 cycles later with `p=16'hFE01` for one cycle.
  - Then IDLE with `in_ready=1`.
- `a=8'h12`, `b=8'h34`, `out_ready=0` for 3 cycles after `out_valid`:
  - `p=16'h03A8` holds stable.
  - `in_ready=0` until `out_ready` rises.
- Back-to-back: in DONE, `out_ready=1` and `in_valid=1` with `a=8'h0F`, `b=8'hF0`:
  - First result retires and the new pair is accepted the same edge.
  - Second result `p=16'h0E10` comes 4 cycles later.
- `EARLY_OUT=1`, `a=8'hC3`, `b=8'h0D`: `p=16'h09E7` 2 cycles after accept.
- `EARLY_OUT=1`, `a=8'hC3`, `b=8'h1D`: `p=16'h1617` 4 cycles after accept.
- Reset mid-MUL (after step 1): `out_valid` stays 0 and `p=16'h0000`. Then 1000 random pairs with random `out_ready`: every `p==a*b`, in order, none dropped.
